// File: rtl/burst_sched_pkg.sv
// Shared definitions for the backscatter burst sequencer:
// state encoding and default widths.
package burst_sched_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int BURST_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ON   = ST_ON,
        S_GAP  = ST_GAP,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; zero flags the last cycle of a window.
// Holds at zero until the next load.
module cycle_timer
    import burst_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/backscatter_burst_scheduler.sv
// Drives the modulator trigger: N bursts of on-window high
// separated by a guaranteed low gap, then a done pulse.
module backscatter_burst_scheduler
    import burst_sched_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_count,
    input  logic [CNT_W-1:0]   on_cycles,
    input  logic [CNT_W-1:0]   gap_cycles,
    input  logic               abort,
    output logic               trigger_signal,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [BURST_W-1:0] burst_index
);

    state_t             state;
    logic [BURST_W-1:0] count_q;
    logic [CNT_W-1:0]   on_q;
    logic [CNT_W-1:0]   gap_q;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_value;
    logic               tmr_zero;
    logic               accept;
    logic               last_burst;

    // A zero length still gets one cycle, so load len-1 clamped at 0.
    function automatic logic [CNT_W-1:0] window(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    assign accept     = start && !abort;
    assign last_burst = (burst_index == count_q - 1'b1);

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state)
            S_IDLE: begin
                if (accept && burst_count != '0) begin
                    tmr_load  = 1'b1;
                    tmr_value = window(on_cycles);
                end
            end
            S_ON: begin
                if (!abort && tmr_zero && !last_burst) begin
                    tmr_load  = 1'b1;
                    tmr_value = window(gap_q);
                end
            end
            S_GAP: begin
                if (!abort && tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_value = window(on_q);
                end
            end
            S_DONE: begin
                tmr_load = 1'b0;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= S_IDLE;
            trigger_signal <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            burst_index    <= '0;
            count_q        <= '0;
            on_q           <= '0;
            gap_q          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        count_q     <= burst_count;
                        on_q        <= on_cycles;
                        gap_q       <= gap_cycles;
                        busy        <= 1'b1;
                        aborted     <= 1'b0;
                        burst_index <= '0;
                        if (burst_count == '0) begin
                            state <= S_DONE;
                        end else begin
                            state          <= S_ON;
                            trigger_signal <= 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (abort) begin
                        state          <= S_DONE;
                        trigger_signal <= 1'b0;
                        aborted        <= 1'b1;
                    end else if (tmr_zero) begin
                        trigger_signal <= 1'b0;
                        state          <= last_burst ? S_DONE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state          <= S_DONE;
                        trigger_signal <= 1'b0;
                        aborted        <= 1'b1;
                    end else if (tmr_zero) begin
                        state          <= S_ON;
                        trigger_signal <= 1'b1;
                        burst_index    <= burst_index + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_backscatter_burst_scheduler.sv
// Randomized bench for the burst scheduler against a
// cycle-list reference model built from burst arithmetic.
module tb_backscatter_burst_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  burst_count = '0;
    logic [15:0] on_cycles = '0;
    logic [15:0] gap_cycles = '0;
    logic        trigger_signal;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  burst_index;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [11:0] exp_q[$];
    logic        last_ab = 1'b0;
    logic [7:0]  last_idx = '0;

    wire [11:0] obs = {trigger_signal, busy, done, aborted, burst_index};

    always #5 clock = ~clock;

    backscatter_burst_scheduler dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .burst_count    (burst_count),
        .on_cycles      (on_cycles),
        .gap_cycles     (gap_cycles),
        .abort          (abort),
        .trigger_signal (trigger_signal),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .burst_index    (burst_index)
    );

    // Expected {trigger,busy,done,aborted,index} for each cycle after start.
    task automatic build(input int cnt, input int on, input int gap,
                         input int abort_at);
        int onl;
        int gapl;
        logic [7:0] b8;
        logic [11:0] tail;
        onl  = (on == 0) ? 1 : on;
        gapl = (gap == 0) ? 1 : gap;
        exp_q.delete();
        if (cnt == 0) begin
            exp_q.push_back({4'b0100, 8'd0});
            exp_q.push_back({4'b0010, 8'd0});
        end else begin
            for (int b = 0; b < cnt; b++) begin
                b8 = 8'(b);
                repeat (onl) exp_q.push_back({4'b1100, b8});
                if (b < cnt - 1)
                    repeat (gapl) exp_q.push_back({4'b0100, b8});
            end
            b8 = 8'(cnt - 1);
            exp_q.push_back({4'b0100, b8});
            exp_q.push_back({4'b0010, b8});
        end
        if (abort_at >= 0) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            tail = exp_q[abort_at];
            b8 = tail[7:0];
            exp_q.push_back({4'b0101, b8});
            exp_q.push_back({4'b0011, b8});
        end
        tail     = exp_q[exp_q.size() - 1];
        last_ab  = tail[8];
        last_idx = tail[7:0];
        exp_q.push_back({3'b000, last_ab, last_idx});
    endtask

    task automatic run_seq(input string name, input int cnt, input int on,
                           input int gap, input int abort_at,
                           input int start_at);
        build(cnt, on, gap, abort_at);
        @(posedge clock);
        #1;
        start       = 1'b1;
        abort       = 1'b0;
        burst_count = 8'(cnt);
        on_cycles   = 16'(on);
        gap_cycles  = 16'(gap);
        @(posedge clock);
        #1;
        start       = 1'b0;
        burst_count = 8'($urandom);
        on_cycles   = 16'($urandom);
        gap_cycles  = 16'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            abort = (k == abort_at);
            start = (k == start_at);
            @(negedge clock);
            total_cnt++;
            if (obs !== exp_q[k])
                $display("FAIL %s cyc %0d: got %h want %h",
                         name, k, obs, exp_q[k]);
            else
                pass_cnt++;
            @(posedge clock);
            #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total_cnt++;
        if (obs !== 12'h000)
            $display("FAIL reset: got %h want %h", obs, 12'h000);
        else
            pass_cnt++;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        run_seq("basic", 3, 5, 2, -1, -1);
    endtask

    task automatic test_zero_count();
        run_seq("zero_count", 0, 7, 3, -1, -1);
    endtask

    task automatic test_clamp();
        run_seq("clamp", 2, 0, 0, -1, -1);
    endtask

    task automatic test_abort();
        run_seq("abort", 4, 10, 4, 16, -1);
    endtask

    task automatic test_start_abort_idle();
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            start       = (i != 3);
            abort       = 1'b1;
            burst_count = 8'($urandom_range(5, 1));
            on_cycles   = 16'($urandom_range(5, 1));
            @(negedge clock);
            total_cnt++;
            if (obs !== {3'b000, last_ab, last_idx})
                $display("FAIL start_abort_idle %0d: got %h want %h",
                         i, obs, {3'b000, last_ab, last_idx});
            else
                pass_cnt++;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_start_busy();
        run_seq("start_in_gap", 2, 3, 2, -1, 4);
        run_seq("start_in_done", 2, 3, 2, -1, 8);
    endtask

    task automatic test_random();
        int cnt, on, gap, onl, gapl, active, ab, st, busy_last;
        for (int n = 0; n < 12; n++) begin
            cnt  = $urandom_range(4, 0);
            on   = $urandom_range(6, 0);
            gap  = $urandom_range(4, 0);
            onl  = (on == 0) ? 1 : on;
            gapl = (gap == 0) ? 1 : gap;
            active = (cnt == 0) ? 0 : cnt * onl + (cnt - 1) * gapl;
            ab = -1;
            if (active > 0 && $urandom_range(1, 0) == 1)
                ab = $urandom_range(active - 1, 0);
            busy_last = (ab >= 0) ? ab + 1 : active;
            st = -1;
            if ($urandom_range(1, 0) == 1)
                st = $urandom_range(busy_last, 0);
            run_seq("random", cnt, on, gap, ab, st);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clock);
        #1;
        start       = 1'b1;
        burst_count = 8'd3;
        on_cycles   = 16'd10;
        gap_cycles  = 16'd2;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        total_cnt++;
        if (obs !== 12'h000)
            $display("FAIL reset_mid: got %h want %h", obs, 12'h000);
        else
            pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total_cnt++;
            if ({done, busy, trigger_signal} !== 3'b000)
                $display("FAIL reset_mid_quiet %0d: got %b want %b",
                         i, {done, busy, trigger_signal}, 3'b000);
            else
                pass_cnt++;
        end
        last_ab  = 1'b0;
        last_idx = '0;
        run_seq("after_reset", 1, 2, 1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_clamp();
        test_abort();
        test_start_abort_idle();
        test_basic();
        test_start_busy();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
